// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for the NxN int8 systolic multiply array.
// Accepts one k-slice per beat (column k of A, row k of B), skews lane i by
// i cycles onto the array's west/north edges, and emits per-anti-diagonal
// push (start accumulation) and done (result ready) pulses.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int KW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*8-1:0]  in_a,
  input  logic [N*8-1:0]  in_b,
  input  logic [KW-1:0]   k_len,
  output logic [N*8-1:0]  a_edge,
  output logic [N*8-1:0]  b_edge,
  output logic [2*N-2:0]  push_diag,
  output logic [2*N-2:0]  done_diag,
  output logic [KW-1:0]   tile_cnt,
  output logic            busy
);

  localparam int D = 2*N - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [KW-1:0] kc;
  logic [KW-1:0] klat;
  logic [KW-1:0] k_eff;
  logic [KW-1:0] kc_next;
  logic          accept;
  logic          first_tag;
  logic          last_tag;
  logic          last_q;
  logic [D-1:0]  push_pipe;
  logic [D-1:0]  done_pipe;
  logic          tags_pending;

  // No internal backpressure: ready in every cycle outside reset.
  assign in_ready = ~reset;
  assign accept   = in_valid & in_ready;

  // Tag decode for the beat being accepted this cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    k_eff     = (k_len == '0) ? KW'(1) : k_len;
    kc_next   = kc + KW'(1);
    first_tag = accept && (state == IDLE);
    last_tag  = 1'b0;
    if (accept) begin
      if (state == IDLE) last_tag = (k_eff == KW'(1));
      else               last_tag = (kc_next == klat);
    end
  end

  // Tile framing FSM: counts beats of the current tile against the latched depth.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      kc    <= '0;
      klat  <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          klat  <= k_eff;
          kc    <= KW'(1);
          state <= last_tag ? IDLE : RUN;
        end
        RUN: begin
          if (last_tag) begin
            state <= IDLE;
            kc    <= '0;
          end else begin
            kc <= kc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skew datapath: lane i carries i+1 register stages.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [7:0] a_sr [0:i];
    logic [7:0] b_sr [0:i];

    // Shift lane i every cycle; cycles without an accept inject zero bubbles.
    // NOTE: these delay stages are reset even though they only carry data,
    // because stale values would leak into the array's accumulations.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else begin
        a_sr[0] <= accept ? in_a[8*i +: 8] : 8'h00;
        b_sr[0] <= accept ? in_b[8*i +: 8] : 8'h00;
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign a_edge[8*i +: 8] = a_sr[i];
    assign b_edge[8*i +: 8] = b_sr[i];
  end

  // First/last tag pipelines; done lags push by one extra stage so the last
  // product has been accumulated before the diagonal is flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_pipe <= '0;
      done_pipe <= '0;
      last_q    <= 1'b0;
    end else begin
      push_pipe <= {push_pipe[D-2:0], first_tag};
      last_q    <= last_tag;
      done_pipe <= {done_pipe[D-2:0], last_q};
    end
  end

  assign push_diag    = push_pipe;
  assign done_diag    = done_pipe;
  assign tags_pending = (|push_pipe) | last_q | (|done_pipe[D-2:0]);

  // Tile completion count and in-flight flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      if (done_pipe[D-1]) tile_cnt <= tile_cnt + KW'(1);
      if (first_tag) begin
        busy <= 1'b1;
      end else if (done_pipe[D-1] && (state == IDLE) && !tags_pending) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the N×N int8 systolic multiply array.
- Accepts one k-slice per beat: column k of A (N int8) and row k of B (N int8), via a valid/ready handshake.
- Skews row i of A and column j of B by i and j cycles onto the array's west and north edges.
- Generates the per-diagonal push pulses that start accumulation, and done strobes marking when each anti-diagonal's out_c holds a finished tile result.

Parameters:
- N, 4, array dimension (rows = cols); N >= 2.
- KW, 16, width of the tile-depth configuration and beat counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  feeder can accept a beat.
- in_a  in  N*8  A column slice; element i at bits [8i+7:8i], signed.
- in_b  in  N*8  B row slice; element j at bits [8j+7:8j], signed.
- k_len  in  KW  beats per tile; sampled on the first beat of each tile; 0 treated as 1.
- a_edge  out  N*8  to in_a of PE(i,0), element i.
- b_edge  out  N*8  to in_b of PE(0,j), element j.
- push_diag  out  2N-1  push to every PE with i+j = d.
- done_diag  out  2N-1  PEs with i+j = d hold the final tile result this cycle.
- tile_cnt  out  KW  completed tiles since reset, wraps.
- busy  out  1  a tile is in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values:
  - a_edge, b_edge, push_diag, done_diag, tile_cnt, busy all 0.
  - All delay stages 0; beat counter 0; FSM in IDLE.
  - in_ready = 0 while reset is high, 1 otherwise.
- Accept: a beat is accepted when in_valid && in_ready. There is no internal backpressure; in_ready is 1 in every non-reset cycle.
- Skew datapath:
  - Beat accepted at edge t: a_edge[i] and b_edge[i] carry it in cycle t+1+i (i extra register stages for lane i).
  - Sign and value pass unmodified.
  - Every cycle without an accept injects 0 into lane entry, so bubbles contribute 0 to the PE accumulations.
- FSM IDLE/RUN with beat counter kc:
  - IDLE + accept: latch klat = max(k_len,1); kc = 1; tag the beat "first". If klat == 1, also tag it "last" and stay IDLE; else go to RUN.
  - RUN + accept: kc += 1; if kc reaches klat, tag the beat "last", return to IDLE, kc = 0.
  - RUN without accept: hold state.
  - k_len is ignored except on a first beat.
- Tag pipelines (2N-1 stages, shift every cycle):
  - A first beat accepted at t drives push_diag[d] = 1 in cycle t+1+d.
  - A last beat accepted at t drives done_diag[d] = 1 in cycle t+2+d.
  - All pulses are exactly 1 cycle wide.
- Back-to-back tiles: push_diag[d] and done_diag[d] for consecutive tiles may coincide in the same cycle. Both assert; out_c is valid in that cycle and is replaced at the next edge.
- tile_cnt increments in the cycle done_diag[2N-2] is high.
- busy:
  - Set on a first-beat accept.
  - Cleared in the cycle after done_diag[2N-2] is high, provided no tile is in RUN and no first/last tag is still in the pipelines.
- Reset mid-tile: all state and pipelines clear at that edge. No further push/done pulses appear for the aborted tile, and tile_cnt is not incremented. The array is reset by the same reset.

Test Plan:
- N=4, k_len=1, single beat A=[1,2,3,4], B=[5,6,7,8] accepted at t=0:
  - a_edge[i] = i+1 in cycle 1+i and 0 otherwise.
  - push_diag[d] in cycle 1+d; done_diag[d] in cycle 2+d.
  - Array PE(i,j).out_c = (i+1)(j+5).
  - tile_cnt = 1.
- k_len=3, three contiguous beats of all -128 for A and B:
  - One push per diagonal; done_diag[6] in cycle 2+2+6 = 10.
  - Every PE accumulates 3*16384 = 49152.
- k_len=3 with bubbles (in_valid low between beats):
  - Zeros appear on the edges during bubbles.
  - Results match the contiguous case; done is shifted by the bubble count.
- Two tiles back-to-back (k_len=2 each):
  - done_diag[d] of tile 0 coincides with push_diag[d] of tile 1 in the same cycle.
  - Sampled results of both tiles are correct; tile_cnt = 2.
- k_len=0 on the first beat: behaves as k_len=1. A k_len change mid-tile is ignored.
- Reset asserted in cycle 3 of a k_len=4 tile:
  - All outputs 0 at the next cycle; no done pulses; tile_cnt stays 0.
  - A following tile starts cleanly.
